// File: rtl/kplic_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | kplic_core: level-triggered interrupt controller with claim/complete flow    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module kplic_core #(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3
) (
    input  logic               cpu_clk,
    input  logic               cpu_rstn,
    input  logic [NUM_SRC-1:0] ext_int_src,
    input  logic               kplic_valid,
    input  logic               kplic_wr,
    input  logic [7:0]         kplic_addr,
    input  logic [31:0]        kplic_wdata,
    output logic [31:0]        kplic_rdata,
    output logic               kplic_rvalid,
    output logic               kplic_int
);

    localparam int         ID_W           = $clog2(NUM_SRC + 1);
    localparam logic [7:0] PENDING_ADDR   = 8'h40;
    localparam logic [7:0] ENABLE_ADDR    = 8'h44;
    localparam logic [7:0] THRESHOLD_ADDR = 8'h48;
    localparam logic [7:0] CLAIM_ADDR     = 8'h4C;

    logic [NUM_SRC-1:0] sync1;
    logic [NUM_SRC-1:0] sync2;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] in_flight;
    logic [NUM_SRC-1:0] enable;
    logic [PRIO_W-1:0]  prio [NUM_SRC];
    logic [PRIO_W-1:0]  threshold;

    logic [ID_W-1:0]    best_id;
    logic [PRIO_W-1:0]  best_prio;
    logic               read_stb;
    logic               write_stb;
    logic               claim_stb;
    logic               complete_stb;
    logic [NUM_SRC-1:0] claim_vec;
    logic [NUM_SRC-1:0] complete_vec;
    logic [NUM_SRC-1:0] prio_sel;
    logic [31:0]        read_mux;

    assign read_stb     = kplic_valid & ~kplic_wr;
    assign write_stb    = kplic_valid & kplic_wr;
    assign claim_stb    = read_stb && (kplic_addr == CLAIM_ADDR);
    assign complete_stb = write_stb && (kplic_addr == CLAIM_ADDR);

    // Strict '>' while scanning upward keeps the lowest ID on priority ties.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pending[i] && enable[i] && (prio[i] > threshold) && (prio[i] > best_prio)) begin
                best_prio = prio[i];
                best_id   = ID_W'(i + 1);
            end
        end
    end

    always_comb begin
        claim_vec    = '0;
        complete_vec = '0;
        prio_sel     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_vec[i]    = claim_stb && (best_id == ID_W'(i + 1));
            complete_vec[i] = complete_stb && (kplic_wdata == 32'(i + 1));
            prio_sel[i]     = (kplic_addr == 8'(4 * i));
        end
    end

    always_comb begin
        read_mux = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (prio_sel[i]) begin
                read_mux = 32'(prio[i]);
            end
        end
        case (kplic_addr)
            PENDING_ADDR:   read_mux = 32'(pending);
            ENABLE_ADDR:    read_mux = 32'(enable);
            THRESHOLD_ADDR: read_mux = 32'(threshold);
            CLAIM_ADDR:     read_mux = 32'(best_id);
            default:        ;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            sync1        <= '0;
            sync2        <= '0;
            pending      <= '0;
            in_flight    <= '0;
            enable       <= '0;
            threshold    <= '0;
            kplic_rdata  <= '0;
            kplic_rvalid <= 1'b0;
            kplic_int    <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                prio[i] <= '0;
            end
        end else begin
            sync1        <= ext_int_src;
            sync2        <= sync1;
            // Claim clears after the gateway set so a simultaneous set loses.
            pending      <= (pending | (sync2 & ~in_flight)) & ~claim_vec;
            in_flight    <= (in_flight & ~complete_vec) | claim_vec;
            kplic_int    <= (best_id != '0);
            kplic_rvalid <= read_stb;
            if (read_stb) begin
                kplic_rdata <= read_mux;
            end
            if (write_stb) begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (prio_sel[i]) begin
                        prio[i] <= kplic_wdata[PRIO_W-1:0];
                    end
                end
                if (kplic_addr == ENABLE_ADDR) begin
                    enable <= kplic_wdata[NUM_SRC-1:0];
                end
                if (kplic_addr == THRESHOLD_ADDR) begin
                    threshold <= kplic_wdata[PRIO_W-1:0];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kplic_core.sv
`default_nettype none
// Testbench for kplic_core: directed scenarios plus a randomized run against
// a behavioural model of the controller.
module tb_kplic_core;

    localparam int N = 8;

    logic        cpu_clk = 1'b0;
    logic        cpu_rstn = 1'b0;
    logic [N-1:0] src = '0;
    logic        valid = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        irq;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [N-1:0] m_pend, m_infl, m_en, m_s1, m_s2;
    int           m_prio [N];
    int           m_thr;
    logic         m_int, m_rvalid;
    logic [31:0]  m_rdata;

    always #5 cpu_clk = ~cpu_clk;

    kplic_core #(.NUM_SRC(N), .PRIO_W(3)) dut (
        .cpu_clk      (cpu_clk),
        .cpu_rstn     (cpu_rstn),
        .ext_int_src  (src),
        .kplic_valid  (valid),
        .kplic_wr     (wr),
        .kplic_addr   (addr),
        .kplic_wdata  (wdata),
        .kplic_rdata  (rdata),
        .kplic_rvalid (rvalid),
        .kplic_int    (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit eligible(input int i);
        return m_pend[i] && m_en[i] && (m_prio[i] > m_thr);
    endfunction

    // Highest eligible priority first, then the lowest ID holding it.
    function automatic int m_best();
        int top = 0;
        for (int i = 0; i < N; i++)
            if (eligible(i) && m_prio[i] > top) top = m_prio[i];
        if (top == 0) return 0;
        for (int i = 0; i < N; i++)
            if (eligible(i) && m_prio[i] == top) return i + 1;
        return 0;
    endfunction

    function automatic logic [31:0] reg_value(input logic [7:0] a, input int b);
        if (a[1:0] == 2'b00 && a < 8'h20) return 32'(m_prio[a >> 2]);
        case (a)
            8'h40:   return 32'(m_pend);
            8'h44:   return 32'(m_en);
            8'h48:   return 32'(m_thr);
            8'h4C:   return 32'(b);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = '0; m_infl = '0; m_en = '0; m_s1 = '0; m_s2 = '0;
        m_thr = 0; m_int = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        for (int i = 0; i < N; i++) m_prio[i] = 0;
    endtask

    task automatic cycle();
        logic         v, w;
        logic [7:0]   a;
        logic [31:0]  d;
        logic [N-1:0] s, gate;
        int           b, id;
        v = valid; w = wr; a = addr; d = wdata; s = src;
        @(posedge cpu_clk);
        b        = m_best();
        gate     = m_s2 & ~m_infl & ~m_pend;
        m_int    = (b != 0);
        m_rvalid = v && !w;
        m_pend   = m_pend | gate;
        if (v && !w) begin
            m_rdata = reg_value(a, b);
            if (a == 8'h4C && b != 0) begin
                m_pend[b-1] = 1'b0;
                m_infl[b-1] = 1'b1;
            end
        end
        if (v && w) begin
            if (a[1:0] == 2'b00 && a < 8'h20) m_prio[a >> 2] = int'(d & 32'd7);
            if (a == 8'h44) m_en = d[N-1:0];
            if (a == 8'h48) m_thr = int'(d & 32'd7);
            if (a == 8'h4C && d >= 1 && d <= N) begin
                id = int'(d);
                m_infl[id-1] = 1'b0;
            end
        end
        m_s2 = m_s1;
        m_s1 = s;
        #1;
        chk("model_int", 32'(irq), 32'(m_int));
        chk("model_rvalid", 32'(rvalid), 32'(m_rvalid));
        if (m_rvalid) chk("model_rdata", rdata, m_rdata);
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
        valid = 1'b1; wr = 1'b1; addr = a; wdata = d;
        cycle();
        valid = 1'b0; wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [31:0] d);
        valid = 1'b1; wr = 1'b0; addr = a;
        cycle();
        valid = 1'b0;
        d = rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        cpu_rstn = 1'b0;
        model_reset();
        #1;
        chk("reset_int", 32'(irq), 32'h0);
        chk("reset_rvalid", 32'(rvalid), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        @(posedge cpu_clk);
        @(posedge cpu_clk);
        #1;
        cpu_rstn = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        int          act;

        // Single source latency through synchronizer and gateway
        src = '0;
        do_reset();
        wr_reg(8'h08, 32'd2);
        wr_reg(8'h44, 32'h04);
        wr_reg(8'h48, 32'd0);
        src = 8'h04;
        idle(3);
        chk("lat_int_before", 32'(irq), 32'h0);
        cycle();
        chk("lat_int_after", 32'(irq), 32'h1);
        rd_reg(8'h40, d);
        chk("lat_pending", d, 32'h04);

        // Priority ordering of successive claims
        src = '0;
        do_reset();
        wr_reg(8'h00, 32'd5);
        wr_reg(8'h04, 32'd5);
        wr_reg(8'h0C, 32'd7);
        wr_reg(8'h44, 32'h0B);
        src = 8'h0B;
        idle(4);
        src = '0;
        rd_reg(8'h4C, d); chk("order_claim1", d, 32'd4);
        rd_reg(8'h4C, d); chk("order_claim2", d, 32'd1);
        rd_reg(8'h4C, d); chk("order_claim3", d, 32'd2);
        chk("order_int_third", 32'(irq), 32'h1);
        rd_reg(8'h4C, d); chk("order_claim4", d, 32'd0);
        chk("order_int_fall", 32'(irq), 32'h0);

        // Threshold masking
        do_reset();
        wr_reg(8'h00, 32'd5);
        wr_reg(8'h44, 32'h01);
        wr_reg(8'h48, 32'd5);
        src = 8'h01;
        idle(4);
        chk("thr_int_masked", 32'(irq), 32'h0);
        rd_reg(8'h4C, d); chk("thr_claim_zero", d, 32'd0);
        wr_reg(8'h48, 32'd4);
        chk("thr_int_1cyc", 32'(irq), 32'h0);
        cycle();
        chk("thr_int_2cyc", 32'(irq), 32'h1);

        // Claim / complete handshake with the source held high
        rd_reg(8'h4C, d); chk("cc_claim", d, 32'd1);
        idle(3);
        rd_reg(8'h40, d); chk("cc_pend_inflight", d, 32'h0);
        chk("cc_int_inflight", 32'(irq), 32'h0);
        wr_reg(8'h4C, 32'd2);
        rd_reg(8'h40, d); chk("cc_bad_complete", d, 32'h0);
        wr_reg(8'h4C, 32'd1);
        cycle();
        rd_reg(8'h40, d); chk("cc_repend", d, 32'h01);
        chk("cc_int_reassert", 32'(irq), 32'h1);

        // Reset between a claim strobe and its rvalid
        valid = 1'b1; wr = 1'b0; addr = 8'h4C;
        #2;
        cpu_rstn = 1'b0;
        valid = 1'b0;
        src = '0;
        model_reset();
        #1;
        chk("midclaim_rvalid", 32'(rvalid), 32'h0);
        chk("midclaim_int", 32'(irq), 32'h0);
        @(posedge cpu_clk);
        #1;
        chk("midclaim_rvalid_edge", 32'(rvalid), 32'h0);
        cpu_rstn = 1'b1;
        rd_reg(8'h40, d); chk("midclaim_pending", d, 32'h0);
        rd_reg(8'h00, d); chk("midclaim_prio1", d, 32'h0);
        rd_reg(8'h4C, d); chk("midclaim_claim", d, 32'h0);

        // Reset while a source is in flight and the interrupt is up
        do_reset();
        wr_reg(8'h08, 32'd6);
        wr_reg(8'h00, 32'd2);
        wr_reg(8'h44, 32'h05);
        src = 8'h05;
        idle(4);
        rd_reg(8'h4C, d); chk("rst_claim3", d, 32'd3);
        cycle();
        chk("rst_int_before", 32'(irq), 32'h1);
        cpu_rstn = 1'b0;
        src = '0;
        model_reset();
        #1;
        chk("rst_int_async", 32'(irq), 32'h0);
        @(posedge cpu_clk);
        #1;
        cpu_rstn = 1'b1;
        rd_reg(8'h40, d); chk("rst_pending", d, 32'h0);
        rd_reg(8'h44, d); chk("rst_enable", d, 32'h0);
        rd_reg(8'h4C, d); chk("rst_claim", d, 32'h0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            act = int'($urandom_range(0, 9));
            case (act)
                0: begin src = N'($urandom); cycle(); end
                1: wr_reg(8'(4 * $urandom_range(0, N - 1)), $urandom);
                2: wr_reg(8'h44, $urandom);
                3: wr_reg(8'h48, 32'($urandom_range(0, 3)));
                4, 5: rd_reg(8'h4C, d);
                6: wr_reg(8'h4C, 32'($urandom_range(0, N + 1)));
                7: rd_reg(8'($urandom) & 8'hFC, d);
                8: wr_reg(8'($urandom_range(8'h50, 8'hFF)) & 8'hFC, $urandom);
                default: cycle();
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
